// File: rtl/edge_detect_veto_multi.sv
// Multi-channel asynchronous pulse edge detector with look-back veto and saturating counters.
// Edges become toggles in the pulse domain, are synchronised into clk, then qualified against recent activity.
module edge_detect_veto_multi #(
   parameter int NCH         = 4,
   parameter int SYNC_STAGES = 3,
   parameter int VETO_DEPTH  = 3,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NCH-1:0]         pulse,
   input  logic [NCH-1:0]         valid,
   input  logic [VETO_DEPTH-1:0]  vetoMask,
   input  logic                   vetoGlobal,
   input  logic                   clearCounts,
   output logic [NCH-1:0]         pulseOut,
   output logic                   pulseAny,
   output logic [NCH*CNT_W-1:0]   acceptCount,
   output logic [NCH*CNT_W-1:0]   vetoCount
);
   localparam int AW = SYNC_STAGES + VETO_DEPTH;

   logic [NCH-1:0]       v_edge;
   logic [NCH-1:0]       suppress;
   logic [NCH-1:0]       accept;
   logic [VETO_DEPTH:1]  act [NCH];
   logic [VETO_DEPTH:1]  any_act;
   logic [NCH-1:0]       pulse_out_q;
   logic                 pulse_any_q;

   always_comb begin
      any_act = '0;
      for (int i = 0; i < NCH; i++) begin
         any_act = any_act | act[i];
      end
   end

   genvar c;
   generate
      for (c = 0; c < NCH; c++) begin : g_ch
         logic                 p_tog_q;
         logic                 a_tog_q;
         logic [SYNC_STAGES-1:0] p_sync_q;
         logic [AW-1:0]        a_sync_q;
         logic [VETO_DEPTH:1]  src;
         logic [CNT_W-1:0]     acc_q, acc_d;
         logic [CNT_W-1:0]     vet_q, vet_d;

         // The pulse itself clocks the toggles so arbitrarily short pulses are never lost.
         always_ff @(posedge pulse[c] or posedge reset) begin
            if (reset) begin
               p_tog_q <= 1'b0;
               a_tog_q <= 1'b0;
            end else begin
               a_tog_q <= ~a_tog_q;
               if (valid[c]) begin
                  p_tog_q <= ~p_tog_q;
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               p_sync_q <= '0;
               a_sync_q <= '0;
            end else begin
               p_sync_q <= {p_sync_q[SYNC_STAGES-2:0], p_tog_q};
               a_sync_q <= {a_sync_q[AW-2:0], a_tog_q};
            end
         end

         // Activity is only taken from k>=1, so an edge (own or simultaneous) never vetoes itself.
         assign v_edge[c]   = p_sync_q[SYNC_STAGES-1] ^ p_sync_q[SYNC_STAGES-2];
         assign act[c]      = a_sync_q[AW-1:SYNC_STAGES] ^ a_sync_q[AW-2:SYNC_STAGES-1];
         assign src         = vetoGlobal ? any_act : act[c];
         assign suppress[c] = |(vetoMask & src);
         assign accept[c]   = v_edge[c] & ~suppress[c];

         always_comb begin
            acc_d = acc_q;
            vet_d = vet_q;
            if (clearCounts) begin
               acc_d = '0;
               vet_d = '0;
            end else begin
               if (accept[c] && (acc_q != {CNT_W{1'b1}})) begin
                  acc_d = acc_q + 1'b1;
               end
               if (v_edge[c] && suppress[c] && (vet_q != {CNT_W{1'b1}})) begin
                  vet_d = vet_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               acc_q <= '0;
               vet_q <= '0;
            end else begin
               acc_q <= acc_d;
               vet_q <= vet_d;
            end
         end

         assign acceptCount[c*CNT_W +: CNT_W] = acc_q;
         assign vetoCount[c*CNT_W +: CNT_W]   = vet_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pulse_out_q <= '0;
         pulse_any_q <= 1'b0;
      end else begin
         pulse_out_q <= accept;
         pulse_any_q <= |pulse_out_q;
      end
   end

   assign pulseOut = pulse_out_q;
   assign pulseAny = pulse_any_q;

endmodule

// File: tb/tb_edge_detect_veto_multi.sv
// Randomised and directed bench for edge_detect_veto_multi; a cycle-level event model feeds a
// scoreboard queue that an independent monitor drains whenever pulseOut is presented.
module tb_edge_detect_veto_multi;
   localparam int NCH  = 4;
   localparam int SS   = 3;
   localparam int VD   = 3;
   localparam int CW   = 4;
   localparam int SATV = (1 << CW) - 1;

   typedef struct {
      int             cyc;
      logic [NCH-1:0] vec;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [NCH-1:0]     pulse = '0;
   logic [NCH-1:0]     valid = '0;
   logic [VD-1:0]      vetoMask = '0;
   logic               vetoGlobal = 1'b0;
   logic               clearCounts = 1'b0;
   logic [NCH-1:0]     pulseOut;
   logic               pulseAny;
   logic [NCH*CW-1:0]  acceptCount;
   logic [NCH*CW-1:0]  vetoCount;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t expq[$];
   logic [NCH-1:0] act_log [int];
   int acc_m [NCH];
   int vet_m [NCH];
   int last_e [NCH];

   edge_detect_veto_multi #(
      .NCH(NCH), .SYNC_STAGES(SS), .VETO_DEPTH(VD), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .pulse(pulse), .valid(valid),
      .vetoMask(vetoMask), .vetoGlobal(vetoGlobal), .clearCounts(clearCounts),
      .pulseOut(pulseOut), .pulseAny(pulseAny),
      .acceptCount(acceptCount), .vetoCount(vetoCount)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Edge issued in cycle n is vetoed if an enabled look-back k finds activity issued in cycle n-k.
   function automatic bit model_suppress(input int ch, input int n);
      for (int k = 1; k <= VD; k++) begin
         if (vetoMask[k-1] && act_log.exists(n - k)) begin
            if (vetoGlobal ? (act_log[n - k] != '0) : act_log[n - k][ch]) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic model_zero();
      for (int c = 0; c < NCH; c++) begin
         acc_m[c] = 0;
         vet_m[c] = 0;
      end
   endtask

   task automatic drive(input logic [NCH-1:0] rise, input logic [NCH-1:0] vld);
      logic [NCH-1:0] ev;
      int n;
      @(posedge clk);
      #1;
      n  = cyc;
      ev = '0;
      if (!reset) begin
         for (int c = 0; c < NCH; c++) begin
            if (rise[c] && vld[c]) begin
               if (model_suppress(c, n)) begin
                  if (vet_m[c] < SATV) vet_m[c]++;
               end else begin
                  ev[c] = 1'b1;
                  if (acc_m[c] < SATV) acc_m[c]++;
               end
            end
         end
         if (rise != '0) act_log[n] = rise;
         if (ev != '0) expq.push_back('{cyc: n + SS, vec: ev});
      end
      valid = vld;
      pulse = rise;
      #3;
      pulse = '0;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) drive('0, '0);
   endtask

   task automatic do_clear();
      @(posedge clk);
      #1;
      clearCounts = 1'b1;
      model_zero();
      @(posedge clk);
      #1;
      clearCounts = 1'b0;
   endtask

   task automatic check_counts(input string tag);
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (acceptCount[c*CW +: CW] !== CW'(acc_m[c])) begin
            errors++;
            $display("FAIL %s acceptCount[%0d] got=%0d required=%0d", tag, c, acceptCount[c*CW +: CW], acc_m[c]);
         end
         checks++;
         if (vetoCount[c*CW +: CW] !== CW'(vet_m[c])) begin
            errors++;
            $display("FAIL %s vetoCount[%0d] got=%0d required=%0d", tag, c, vetoCount[c*CW +: CW], vet_m[c]);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if (pulseOut !== '0 || pulseAny !== 1'b0 || acceptCount !== '0 || vetoCount !== '0) begin
         errors++;
         $display("FAIL %s outputs got pulseOut=%b pulseAny=%b acc=%h veto=%h required all zero",
                  tag, pulseOut, pulseAny, acceptCount, vetoCount);
      end
   endtask

   initial begin : monitor
      exp_t e;
      logic [NCH-1:0] last_vec;
      last_vec = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            last_vec = '0;
         end else begin
            checks++;
            if (pulseAny !== (last_vec != '0)) begin
               errors++;
               $display("FAIL pulse_any cyc=%0d got=%b required=%b", cyc, pulseAny, (last_vec != '0));
            end
            last_vec = '0;
            if (pulseOut != '0) begin
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL pulse_out_unexpected cyc=%0d got=%b required=none", cyc, pulseOut);
               end else begin
                  e = expq.pop_front();
                  last_vec = e.vec;
                  if (pulseOut !== e.vec || cyc < e.cyc || cyc > e.cyc + 1) begin
                     errors++;
                     $display("FAIL pulse_out cyc=%0d got=%b required=%b at cyc %0d", cyc, pulseOut, e.vec, e.cyc);
                  end
               end
            end else if (expq.size() != 0 && expq[0].cyc + 1 < cyc) begin
               checks++;
               errors++;
               e = expq.pop_front();
               $display("FAIL pulse_out_missing cyc=%0d got=0 required=%b at cyc %0d", cyc, e.vec, e.cyc);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin : stim
      model_zero();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      reset = 1'b0;
      idle(4);
      check_zero("post_reset_idle");

      // Single valid edge, no veto.
      drive(4'b0100, 4'b0100);
      idle(8);
      check_counts("single_ch2");

      // Own-channel veto one cycle back.
      do_clear();
      vetoMask = 3'b001; vetoGlobal = 1'b0;
      drive(4'b0001, 4'b0001);
      drive(4'b0001, 4'b0001);
      idle(8);
      check_counts("own_veto_k1");

      // Invalid edge on ch1 vetoes ch3 three cycles later only when global.
      do_clear();
      vetoMask = 3'b100; vetoGlobal = 1'b1;
      drive(4'b0010, 4'b0000);
      idle(2);
      drive(4'b1000, 4'b1000);
      idle(8);
      check_counts("global_veto_k3");
      vetoGlobal = 1'b0;
      drive(4'b0010, 4'b0000);
      idle(2);
      drive(4'b1000, 4'b1000);
      idle(8);
      check_counts("local_no_veto_k3");

      // Simultaneous edges never veto each other.
      do_clear();
      vetoMask = 3'b111; vetoGlobal = 1'b1;
      drive(4'b0011, 4'b0011);
      idle(8);
      check_counts("simultaneous");

      // Saturation, then clear on the very edge that registers an accept.
      do_clear();
      vetoMask = 3'b000; vetoGlobal = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(4'b0001, 4'b0001);
         idle(2);
      end
      idle(6);
      check_counts("saturate");
      drive(4'b0001, 4'b0001);
      idle(SS - 1);
      clearCounts = 1'b1;
      model_zero();
      idle(1);
      clearCounts = 1'b0;
      idle(8);
      check_counts("clear_priority");

      // Reset between edge and pulseOut aborts the event; edges during reset are discarded.
      drive(4'b1111, 4'b1111);
      idle(8);
      drive(4'b0001, 4'b0001);
      @(posedge clk);
      #1;
      reset = 1'b1;
      expq.delete();
      act_log.delete();
      model_zero();
      #1;
      check_zero("reset_mid_event");
      drive(4'b0001, 4'b0001);
      idle(2);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(9);
      check_zero("after_release");
      drive(4'b0001, 4'b0001);
      idle(8);
      check_counts("edge_after_release");

      // Randomised phases: fixed mask/global per phase, edges at least two cycles apart per channel.
      for (int c = 0; c < NCH; c++) last_e[c] = -100;
      for (int p = 0; p < 8; p++) begin
         vetoMask   = VD'($urandom);
         vetoGlobal = 1'($urandom);
         do_clear();
         for (int t = 0; t < 30; t++) begin
            logic [NCH-1:0] r;
            logic [NCH-1:0] v;
            r = '0;
            v = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
               if ((cyc + 1 - last_e[c] >= 2) && ($urandom_range(0, 2) == 0)) begin
                  r[c] = 1'b1;
                  last_e[c] = cyc + 1;
               end
            end
            drive(r, v);
         end
         idle(SS + VD + 3);
         check_counts("random_phase");
      end

      idle(4);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending required=0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
